// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the two FUs, the mispredict source and the CDB arbiter.
// The arbiter takes the slave view; FU/ROB-side logic (or a bench) takes the master view.
interface cdb_arbiter_if #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ROB_IDX_W = 4
);
    logic                 in_rob_is_mispred;

    logic                 in_alu_valid;
    logic [DATA_W-1:0]    in_alu_value;
    logic [ROB_IDX_W-1:0] in_alu_dst_rob_index;
    logic                 in_alu_set_nzcv;
    logic [3:0]           in_alu_nzcv;
    logic                 out_alu_ready;

    logic                 in_ls_valid;
    logic [DATA_W-1:0]    in_ls_value;
    logic [ROB_IDX_W-1:0] in_ls_dst_rob_index;
    logic                 out_ls_ready;

    logic                 out_broadcast_done;
    logic [ROB_IDX_W-1:0] out_broadcast_index;
    logic [DATA_W-1:0]    out_broadcast_value;
    logic                 out_broadcast_set_nzcv;
    logic [3:0]           out_broadcast_nzcv;
    logic                 out_broadcast_src;
    logic                 out_busy;

    modport slave (
        input  in_rob_is_mispred,
        input  in_alu_valid, in_alu_value, in_alu_dst_rob_index, in_alu_set_nzcv, in_alu_nzcv,
        output out_alu_ready,
        input  in_ls_valid, in_ls_value, in_ls_dst_rob_index,
        output out_ls_ready,
        output out_broadcast_done, out_broadcast_index, out_broadcast_value,
        output out_broadcast_set_nzcv, out_broadcast_nzcv, out_broadcast_src, out_busy
    );

    modport master (
        output in_rob_is_mispred,
        output in_alu_valid, in_alu_value, in_alu_dst_rob_index, in_alu_set_nzcv, in_alu_nzcv,
        input  out_alu_ready,
        output in_ls_valid, in_ls_value, in_ls_dst_rob_index,
        input  out_ls_ready,
        input  out_broadcast_done, out_broadcast_index, out_broadcast_value,
        input  out_broadcast_set_nzcv, out_broadcast_nzcv, out_broadcast_src, out_busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs (ALU, LS) drained one result per cycle onto a
// registered broadcast bus with round-robin grant; a mispredict flushes everything queued.
module cdb_arbiter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned QDEPTH    = 2
) (
    input logic         in_clk,
    input logic         in_rst,
    cdb_arbiter_if.slave cdb
);
    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(QDEPTH);

    logic [DATA_W-1:0]    r_alu_value [QDEPTH];
    logic [ROB_IDX_W-1:0] r_alu_index [QDEPTH];
    logic                 r_alu_set   [QDEPTH];
    logic [3:0]           r_alu_nzcv  [QDEPTH];
    logic [DATA_W-1:0]    r_ls_value  [QDEPTH];
    logic [ROB_IDX_W-1:0] r_ls_index  [QDEPTH];

    logic [PtrW-1:0] r_alu_rd_ptr, r_alu_wr_ptr, r_ls_rd_ptr, r_ls_wr_ptr;
    logic [CntW-1:0] r_alu_cnt, r_ls_cnt;
    logic            r_last_grant;

    logic                 r_done;
    logic [ROB_IDX_W-1:0] r_index;
    logic [DATA_W-1:0]    r_value;
    logic                 r_set_nzcv;
    logic [3:0]           r_nzcv;
    logic                 r_src;

    logic w_alu_ready, w_ls_ready, w_alu_push, w_ls_push;
    logic w_alu_ne, w_ls_ne, w_grant_alu, w_grant_ls;

    // Ready looks only at the registered count, so a full FIFO refuses even when popped.
    always_comb begin
        w_alu_ready = (r_alu_cnt < CntFull) & ~in_rst;
        w_ls_ready  = (r_ls_cnt < CntFull) & ~in_rst;
        w_alu_push  = cdb.in_alu_valid & w_alu_ready & ~cdb.in_rob_is_mispred;
        w_ls_push   = cdb.in_ls_valid & w_ls_ready & ~cdb.in_rob_is_mispred;
        w_alu_ne    = (r_alu_cnt != '0);
        w_ls_ne     = (r_ls_cnt != '0);
        w_grant_alu = ~cdb.in_rob_is_mispred & w_alu_ne & (~w_ls_ne | r_last_grant);
        w_grant_ls  = ~cdb.in_rob_is_mispred & w_ls_ne & (~w_alu_ne | ~r_last_grant);
    end

    always_ff @(posedge in_clk) begin
        if (w_alu_push) begin
            r_alu_value[r_alu_wr_ptr] <= cdb.in_alu_value;
            r_alu_index[r_alu_wr_ptr] <= cdb.in_alu_dst_rob_index;
            r_alu_set[r_alu_wr_ptr]   <= cdb.in_alu_set_nzcv;
            r_alu_nzcv[r_alu_wr_ptr]  <= cdb.in_alu_nzcv;
        end
        if (w_ls_push) begin
            r_ls_value[r_ls_wr_ptr] <= cdb.in_ls_value;
            r_ls_index[r_ls_wr_ptr] <= cdb.in_ls_dst_rob_index;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_alu_rd_ptr <= '0;
            r_alu_wr_ptr <= '0;
            r_ls_rd_ptr  <= '0;
            r_ls_wr_ptr  <= '0;
            r_alu_cnt    <= '0;
            r_ls_cnt     <= '0;
            r_last_grant <= 1'b0;
            r_done       <= 1'b0;
            r_index      <= '0;
            r_value      <= '0;
            r_set_nzcv   <= 1'b0;
            r_nzcv       <= '0;
            r_src        <= 1'b0;
        end else if (cdb.in_rob_is_mispred) begin
            // Flush keeps last_grant so fairness carries across the mispredict.
            r_alu_rd_ptr <= '0;
            r_alu_wr_ptr <= '0;
            r_ls_rd_ptr  <= '0;
            r_ls_wr_ptr  <= '0;
            r_alu_cnt    <= '0;
            r_ls_cnt     <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_alu_push) r_alu_wr_ptr <= r_alu_wr_ptr + PtrW'(1);
            if (w_ls_push)  r_ls_wr_ptr  <= r_ls_wr_ptr + PtrW'(1);
            if (w_grant_alu) r_alu_rd_ptr <= r_alu_rd_ptr + PtrW'(1);
            if (w_grant_ls)  r_ls_rd_ptr  <= r_ls_rd_ptr + PtrW'(1);
            r_alu_cnt <= r_alu_cnt + CntW'(w_alu_push) - CntW'(w_grant_alu);
            r_ls_cnt  <= r_ls_cnt + CntW'(w_ls_push) - CntW'(w_grant_ls);
            r_done    <= w_grant_alu | w_grant_ls;
            if (w_grant_alu) begin
                r_index      <= r_alu_index[r_alu_rd_ptr];
                r_value      <= r_alu_value[r_alu_rd_ptr];
                r_set_nzcv   <= r_alu_set[r_alu_rd_ptr];
                r_nzcv       <= r_alu_nzcv[r_alu_rd_ptr];
                r_src        <= 1'b0;
                r_last_grant <= 1'b0;
            end else if (w_grant_ls) begin
                r_index      <= r_ls_index[r_ls_rd_ptr];
                r_value      <= r_ls_value[r_ls_rd_ptr];
                r_set_nzcv   <= 1'b0;
                r_nzcv       <= '0;
                r_src        <= 1'b1;
                r_last_grant <= 1'b1;
            end
        end
    end

    assign cdb.out_alu_ready          = w_alu_ready;
    assign cdb.out_ls_ready           = w_ls_ready;
    assign cdb.out_broadcast_done     = r_done;
    assign cdb.out_broadcast_index    = r_index;
    assign cdb.out_broadcast_value    = r_value;
    assign cdb.out_broadcast_set_nzcv = r_set_nzcv;
    assign cdb.out_broadcast_nzcv     = r_nzcv;
    assign cdb.out_broadcast_src      = r_src;
    assign cdb.out_busy               = w_alu_ne | w_ls_ne;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed stimulus pushes hand-ordered expected broadcasts into a queue;
// a negedge monitor pops and compares every bus cycle with done asserted.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(64), .ROB_IDX_W(4)) cdb ();

    cdb_arbiter #(.DATA_W(64), .ROB_IDX_W(4), .QDEPTH(2)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .cdb    (cdb.slave)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [63:0] value;
        logic        set_nzcv;
        logic [3:0]  nzcv;
        logic        src;
    } bc_t;

    bc_t exp_q[$];
    bc_t mon_got, mon_want;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_bc(input logic [3:0] idx, input logic [63:0] value, input logic set,
                             input logic [3:0] nzcv, input logic src);
        bc_t e;
        e.idx = idx; e.value = value; e.set_nzcv = set; e.nzcv = nzcv; e.src = src;
        exp_q.push_back(e);
    endtask

    task automatic alu_drive(input logic v, input logic [3:0] idx, input logic [63:0] value,
                             input logic set, input logic [3:0] nzcv);
        cdb.in_alu_valid = v; cdb.in_alu_dst_rob_index = idx; cdb.in_alu_value = value;
        cdb.in_alu_set_nzcv = set; cdb.in_alu_nzcv = nzcv;
    endtask

    task automatic ls_drive(input logic v, input logic [3:0] idx, input logic [63:0] value);
        cdb.in_ls_valid = v; cdb.in_ls_dst_rob_index = idx; cdb.in_ls_value = value;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && cdb.out_broadcast_done === 1'b1) begin
            mon_got.idx      = cdb.out_broadcast_index;
            mon_got.value    = cdb.out_broadcast_value;
            mon_got.set_nzcv = cdb.out_broadcast_set_nzcv;
            mon_got.nzcv     = cdb.out_broadcast_nzcv;
            mon_got.src      = cdb.out_broadcast_src;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_broadcast: got idx %0d value %0h want no broadcast",
                         mon_got.idx, mon_got.value);
            end else begin
                mon_want = exp_q.pop_front();
                check("broadcast", {54'd0, mon_got}, {54'd0, mon_want});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ai, li, cyc, w;
        logic acc_a, acc_l;
        cdb.in_rob_is_mispred = 1'b0;
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        ls_drive(1'b0, 4'd0, 64'd0);

        // Reset, then idle
        #1 rst = 1'b1;
        #1;
        check("rst_done", cdb.out_broadcast_done, 0);
        check("rst_alu_ready", cdb.out_alu_ready, 0);
        check("rst_ls_ready", cdb.out_ls_ready, 0);
        check("rst_busy", cdb.out_busy, 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("idle_alu_ready", cdb.out_alu_ready, 1);
        check("idle_ls_ready", cdb.out_ls_ready, 1);
        check("idle_done", cdb.out_broadcast_done, 0);
        check("idle_busy", cdb.out_busy, 0);

        // Single ALU result
        step();
        alu_drive(1'b1, 4'd3, 64'h2A, 1'b1, 4'b0100);
        expect_bc(4'd3, 64'h2A, 1'b1, 4'b0100, 1'b0);
        step();
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        check("single_no_bypass", cdb.out_broadcast_done, 0);
        check("single_busy", cdb.out_busy, 1);
        step();
        check("single_done", cdb.out_broadcast_done, 1);
        step();
        check("single_done_drop", cdb.out_broadcast_done, 0);

        // Contention: expected bus order 1, 5, 2, 6
        alu_drive(1'b1, 4'd1, 64'h11, 1'b0, 4'h0);
        expect_bc(4'd1, 64'h11, 1'b0, 4'h0, 1'b0);
        step();
        alu_drive(1'b1, 4'd2, 64'h22, 1'b1, 4'hF);
        ls_drive(1'b1, 4'd5, 64'h55);
        expect_bc(4'd5, 64'h55, 1'b0, 4'h0, 1'b1);
        expect_bc(4'd2, 64'h22, 1'b1, 4'hF, 1'b0);
        step();
        check("cont_done_b", cdb.out_broadcast_done, 1);
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        ls_drive(1'b1, 4'd6, 64'h66);
        expect_bc(4'd6, 64'h66, 1'b0, 4'h0, 1'b1);
        step();
        ls_drive(1'b0, 4'd0, 64'd0);
        check("cont_done_c", cdb.out_broadcast_done, 1);
        check("cont_src_c", cdb.out_broadcast_src, 1);
        step();
        check("cont_done_d", cdb.out_broadcast_done, 1);
        check("cont_src_d", cdb.out_broadcast_src, 0);
        step();
        check("cont_done_e", cdb.out_broadcast_done, 1);
        check("cont_src_e", cdb.out_broadcast_src, 1);
        step();
        check("cont_drained_done", cdb.out_broadcast_done, 0);
        check("cont_drained_busy", cdb.out_busy, 0);

        // Backpressure: both FUs stream 6 results; grants alternate starting with ALU
        for (int k = 0; k < 6; k++) begin
            expect_bc(4'(k), 64'h100 + 64'(k), k[0], 4'(k), 1'b0);
            expect_bc(4'(8 + k), 64'h200 + 64'(k), 1'b0, 4'h0, 1'b1);
        end
        ai = 0; li = 0; cyc = 0;
        alu_drive(1'b1, 4'd0, 64'h100, 1'b0, 4'd0);
        ls_drive(1'b1, 4'd8, 64'h200);
        while ((ai < 6 || li < 6) && cyc < 40) begin
            acc_a = cdb.in_alu_valid & cdb.out_alu_ready;
            acc_l = cdb.in_ls_valid & cdb.out_ls_ready;
            step();
            if (acc_a) begin
                ai++;
                if (ai < 6) alu_drive(1'b1, 4'(ai), 64'h100 + 64'(ai), ai[0], 4'(ai));
                else alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
            end
            if (acc_l) begin
                li++;
                if (li < 6) ls_drive(1'b1, 4'(8 + li), 64'h200 + 64'(li));
                else ls_drive(1'b0, 4'd0, 64'd0);
            end
            if (cyc == 2) begin
                check("bp_alu_full", cdb.out_alu_ready, 0);
                check("bp_ls_room", cdb.out_ls_ready, 1);
            end
            if (cyc == 3) begin
                check("bp_alu_room", cdb.out_alu_ready, 1);
                check("bp_ls_full", cdb.out_ls_ready, 0);
            end
            cyc++;
        end
        check("bp_alu_accepted", 128'(ai), 6);
        check("bp_ls_accepted", 128'(li), 6);
        w = 0;
        while ((exp_q.size() != 0 || cdb.out_busy) && w < 40) begin
            step();
            w++;
        end
        check("bp_drain", 128'(exp_q.size()), 0);
        step();
        check("bp_idle_done", cdb.out_broadcast_done, 0);

        // Flush: 7, 8 and 9 must never appear
        alu_drive(1'b1, 4'd7, 64'h77, 1'b0, 4'd0);
        ls_drive(1'b1, 4'd8, 64'h88);
        step();
        check("flush_busy_before", cdb.out_busy, 1);
        alu_drive(1'b1, 4'd9, 64'h99, 1'b0, 4'd0);
        ls_drive(1'b0, 4'd0, 64'd0);
        cdb.in_rob_is_mispred = 1'b1;
        step();
        cdb.in_rob_is_mispred = 1'b0;
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        check("flush_done", cdb.out_broadcast_done, 0);
        check("flush_busy", cdb.out_busy, 0);
        check("flush_alu_ready", cdb.out_alu_ready, 1);
        check("flush_ls_ready", cdb.out_ls_ready, 1);
        step(); step();
        check("flush_quiet", cdb.out_broadcast_done, 0);

        // last_grant survived the flush as LS, so ALU wins the next tie
        alu_drive(1'b1, 4'd10, 64'hA0, 1'b1, 4'h3);
        ls_drive(1'b1, 4'd11, 64'hB0);
        expect_bc(4'd10, 64'hA0, 1'b1, 4'h3, 1'b0);
        expect_bc(4'd11, 64'hB0, 1'b0, 4'h0, 1'b1);
        step();
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        ls_drive(1'b0, 4'd0, 64'd0);
        step(); step(); step();
        check("tie_done_drop", cdb.out_broadcast_done, 0);
        check("tie_drained", 128'(exp_q.size()), 0);

        // Asynchronous reset mid-broadcast discards the bus value and queued LS entry
        alu_drive(1'b1, 4'd12, 64'hC0, 1'b1, 4'hA);
        ls_drive(1'b1, 4'd13, 64'hD0);
        step();
        alu_drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
        ls_drive(1'b0, 4'd0, 64'd0);
        step();
        #1 rst = 1'b1;
        #1;
        check("arst_done", cdb.out_broadcast_done, 0);
        check("arst_index", cdb.out_broadcast_index, 0);
        check("arst_value", cdb.out_broadcast_value, 0);
        check("arst_set_nzcv", cdb.out_broadcast_set_nzcv, 0);
        check("arst_nzcv", cdb.out_broadcast_nzcv, 0);
        check("arst_busy", cdb.out_busy, 0);
        check("arst_alu_ready", cdb.out_alu_ready, 0);
        check("arst_ls_ready", cdb.out_ls_ready, 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", cdb.out_alu_ready, 1);
        check("post_rst_ls_ready", cdb.out_ls_ready, 1);
        step(); step(); step();
        check("post_rst_done", cdb.out_broadcast_done, 0);
        check("post_rst_busy", cdb.out_busy, 0);
        check("leftover_expected", 128'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
